// File: rtl/jt51_kon_sched.sv
// Key-on scheduler: owns the 32-slot counter and buffers CPU key-on writes.
// Each write is committed at its channel's last operator slot so a channel's operators switch together.
module jt51_kon_sched #(
    parameter int FIFO_DEPTH = 4,
    parameter int LW         = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [2:0]    wr_ch,
    input  logic [3:0]    wr_opmask,
    input  logic [2:0]    rd_ch,
    output logic [3:0]    rd_mask,
    output logic [LW:0]   fifo_level,
    output logic          busy,
    output logic [4:0]    slot_II,
    output logic          keyon_II,
    output logic          zero
);

    localparam int          PW       = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [LW:0] FULL_LVL = (LW+1)'(FIFO_DEPTH);

    logic [4:0]    slot_cnt_r;
    logic [31:0]   kon_state_r;
    logic [2:0]    fifo_ch_r   [FIFO_DEPTH];
    logic [3:0]    fifo_mask_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [LW:0]   level_r;
    logic          ready_r;
    logic          busy_r;
    logic [4:0]    slot_ii_r;
    logic          keyon_ii_r;
    logic          zero_r;

    logic          push_s;
    logic          pop_s;
    logic [2:0]    head_ch_s;
    logic [3:0]    head_mask_s;
    logic [LW:0]   level_nxt_s;
    logic [31:0]   kon_nxt_s;

    // Handshake, commit detection and next FIFO level
    always_comb begin
        push_s      = wr_valid && ready_r;
        head_ch_s   = fifo_ch_r[rd_ptr_r];
        head_mask_s = fifo_mask_r[rd_ptr_r];
        // Slot {3,ch} is the last visit of the channel in a frame, so all four ops flip together
        pop_s       = cen && (level_r != '0) && (slot_cnt_r == {2'b11, head_ch_s});
        if (push_s && !pop_s) begin
            level_nxt_s = level_r + (LW+1)'(1);
        end else if (pop_s && !push_s) begin
            level_nxt_s = level_r - (LW+1)'(1);
        end else begin
            level_nxt_s = level_r;
        end
    end

    // Next key state: the head mask overwrites the four operator bits of its channel
    always_comb begin
        kon_nxt_s = kon_state_r;
        if (pop_s) begin
            for (int i = 0; i < 4; i++) begin
                kon_nxt_s[{2'(i), head_ch_s}] = head_mask_s[i];
            end
        end else begin
            kon_nxt_s = kon_state_r;
        end
    end

    // Slot counter and aligned serial output stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_cnt_r <= 5'd0;
            slot_ii_r  <= 5'd0;
            keyon_ii_r <= 1'b0;
            zero_r     <= 1'b0;
        end else if (cen) begin
            slot_ii_r  <= slot_cnt_r;
            keyon_ii_r <= kon_state_r[slot_cnt_r];
            zero_r     <= (slot_cnt_r == 5'd0);
            slot_cnt_r <= slot_cnt_r + 5'd1;
        end
    end

    // Committed key state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            kon_state_r <= 32'd0;
        end else begin
            kon_state_r <= kon_nxt_s;
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_ch_r[i]   <= 3'd0;
                fifo_mask_r[i] <= 4'd0;
            end
        end else if (push_s) begin
            fifo_ch_r[wr_ptr_r]   <= wr_ch;
            fifo_mask_r[wr_ptr_r] <= wr_opmask;
        end
    end

    // FIFO pointers, level and registered status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            ready_r  <= 1'b1;
            busy_r   <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            level_r <= level_nxt_s;
            ready_r <= (level_nxt_s != FULL_LVL);
            busy_r  <= (level_nxt_s != '0);
        end
    end

    assign wr_ready   = ready_r;
    assign fifo_level = level_r;
    assign busy       = busy_r;
    assign slot_II    = slot_ii_r;
    assign keyon_II   = keyon_ii_r;
    assign zero       = zero_r;
    assign rd_mask    = {kon_state_r[{2'b11, rd_ch}], kon_state_r[{2'b10, rd_ch}],
                         kon_state_r[{2'b01, rd_ch}], kon_state_r[{2'b00, rd_ch}]};

endmodule

// File: tb/tb_jt51_kon_sched.sv
// Directed bench for jt51_kon_sched: reset, commit timing, same-channel sequencing,
// back-pressure, mid-run reset and clock-enable gating.
`timescale 1ns/1ps
module tb_jt51_kon_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cen;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_ch;
    logic [3:0] wr_opmask;
    logic [2:0] rd_ch;
    logic [3:0] rd_mask;
    logic [3:0] fifo_level;
    logic       busy;
    logic [4:0] slot_II;
    logic       keyon_II;
    logic       zero;

    int n_checks = 0;
    int n_errors = 0;

    // bench-side expectations: slot counter, aligned outputs, per-channel committed masks
    logic [4:0] slot_m;
    logic [4:0] e_slot;
    logic       e_zero;
    logic       e_kon;
    logic [3:0] exp_mask [8];

    jt51_kon_sched #(.FIFO_DEPTH(4), .LW(3)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ch(wr_ch), .wr_opmask(wr_opmask),
        .rd_ch(rd_ch), .rd_mask(rd_mask), .fifo_level(fifo_level), .busy(busy),
        .slot_II(slot_II), .keyon_II(keyon_II), .zero(zero)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // one posedge with the inputs as currently driven; returns at the next negedge
    task automatic step();
        if (!rst_n) begin
            slot_m = 5'd0; e_slot = 5'd0; e_zero = 1'b0; e_kon = 1'b0;
        end else if (cen) begin
            e_slot = slot_m;
            e_zero = (slot_m == 5'd0);
            e_kon  = exp_mask[slot_m[2:0]][slot_m[4:3]];
            slot_m = slot_m + 5'd1;
        end
        @(negedge clk);
    endtask

    task automatic chk_pipe();
        chk("slot_II", 32'(slot_II), 32'(e_slot));
        chk("zero", 32'(zero), 32'(e_zero));
        chk("keyon_II", 32'(keyon_II), 32'(e_kon));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            chk_pipe();
        end
    endtask

    task automatic run_to(input logic [4:0] s);
        int guard = 0;
        while (slot_m != s && guard < 64) begin
            step();
            chk_pipe();
            guard++;
        end
        if (guard >= 64) chk("run_to_timeout", 32'(slot_m), 32'(s));
    endtask

    task automatic push(input logic [2:0] ch, input logic [3:0] m);
        wr_valid = 1'b1; wr_ch = ch; wr_opmask = m;
        step();
        chk_pipe();
        wr_valid = 1'b0;
    endtask

    task automatic chk_rd_all();
        for (int c = 0; c < 8; c++) begin
            rd_ch = 3'(c);
            #1;
            chk("rd_mask", 32'(rd_mask), 32'(exp_mask[c]));
        end
    endtask

    initial begin
        bit       done;
        logic [4:0] pre;
        logic       pc;
        for (int c = 0; c < 8; c++) exp_mask[c] = 4'd0;
        slot_m = 5'd0; e_slot = 5'd0; e_zero = 1'b0; e_kon = 1'b0;
        rst_n = 1'b0; cen = 1'b1; wr_valid = 1'b0; wr_ch = 3'd0; wr_opmask = 4'd0; rd_ch = 3'd0;

        // reset held for 3 clocks
        step(); step(); step();
        chk("rst_keyon", 32'(keyon_II), 32'd0);
        chk("rst_slot", 32'(slot_II), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_ready", 32'(wr_ready), 32'd1);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // first cen after release shows slot 0 with zero, and again 32 cen later
        rst_n = 1'b1;
        step(); chk_pipe();
        chk("first_zero", 32'(zero), 32'd1);
        chk("first_slot", 32'(slot_II), 32'd0);
        run(32);
        chk("frame_zero", 32'(zero), 32'd1);

        // single commit: ch2 mask F pushed at slot 5, commits at slot 26
        run_to(5'd5);
        push(3'd2, 4'hF);
        chk("push_level", 32'(fifo_level), 32'd1);
        chk("push_busy", 32'(busy), 32'd1);
        run_to(5'd26);
        step(); chk_pipe();
        chk("commit_slot", 32'(slot_II), 32'd26);
        chk("commit_old_kon", 32'(keyon_II), 32'd0);
        chk("commit_level", 32'(fifo_level), 32'd0);
        exp_mask[2] = 4'hF;
        rd_ch = 3'd2; #1;
        chk("rd_ch2", 32'(rd_mask), 32'hF);
        run(32);

        // same channel twice: 0101 visible for exactly one frame, then 0000
        push(3'd5, 4'b0101);
        push(3'd5, 4'b0000);
        chk("seq_level2", 32'(fifo_level), 32'd2);
        run_to(5'd29);
        step(); chk_pipe();
        exp_mask[5] = 4'b0101;
        chk("seq_level1", 32'(fifo_level), 32'd1);
        rd_ch = 3'd5; #1;
        chk("rd_ch5_a", 32'(rd_mask), 32'h5);
        run(31);
        chk("seq_still_one", 32'(fifo_level), 32'd1);
        step(); chk_pipe();
        exp_mask[5] = 4'b0000;
        chk("seq_level0", 32'(fifo_level), 32'd0);
        chk("rd_ch5_b", 32'(rd_mask), 32'h0);
        run(32);

        // back-pressure with the pipeline frozen
        cen = 1'b0;
        push(3'd0, 4'h1);
        push(3'd1, 4'h3);
        push(3'd3, 4'h7);
        push(3'd4, 4'hF);
        chk("bp_level", 32'(fifo_level), 32'd4);
        chk("bp_ready", 32'(wr_ready), 32'd0);
        wr_valid = 1'b1; wr_ch = 3'd6; wr_opmask = 4'h8;
        step(); chk_pipe();
        step(); chk_pipe();
        chk("bp_hold_level", 32'(fifo_level), 32'd4);
        chk("bp_hold_ready", 32'(wr_ready), 32'd0);
        cen = 1'b1;
        run_to(5'd24);
        step(); chk_pipe();
        exp_mask[0] = 4'h1;
        chk("bp_pop_level", 32'(fifo_level), 32'd3);
        chk("bp_pop_ready", 32'(wr_ready), 32'd1);
        step(); chk_pipe();
        wr_valid = 1'b0;
        exp_mask[1] = 4'h3;
        chk("bp_pushpop_level", 32'(fifo_level), 32'd3);
        step(); chk_pipe();
        chk("bp_lvl26", 32'(fifo_level), 32'd3);
        step(); chk_pipe();
        exp_mask[3] = 4'h7;
        chk("bp_lvl27", 32'(fifo_level), 32'd2);
        step(); chk_pipe();
        exp_mask[4] = 4'hF;
        chk("bp_lvl28", 32'(fifo_level), 32'd1);
        step(); chk_pipe();
        step(); chk_pipe();
        exp_mask[6] = 4'h8;
        chk("bp_lvl30", 32'(fifo_level), 32'd0);
        chk("bp_busy", 32'(busy), 32'd0);
        run(32);
        chk_rd_all();

        // reset mid-operation with ch0=F committed and two entries pending
        push(3'd0, 4'hF);
        run_to(5'd24);
        step(); chk_pipe();
        exp_mask[0] = 4'hF;
        cen = 1'b0;
        push(3'd7, 4'hF);
        push(3'd0, 4'h0);
        chk("mid_level", 32'(fifo_level), 32'd2);
        rst_n = 1'b0; cen = 1'b1;
        step();
        for (int c = 0; c < 8; c++) exp_mask[c] = 4'd0;
        chk("mid_rst_level", 32'(fifo_level), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(wr_ready), 32'd1);
        chk("mid_rst_keyon", 32'(keyon_II), 32'd0);
        chk("mid_rst_slot", 32'(slot_II), 32'd0);
        chk("mid_rst_zero", 32'(zero), 32'd0);
        rst_n = 1'b1;
        run(70);
        chk_rd_all();

        // cen every other clock; ch7 mask 1001 must still commit at slot 31
        done = 1'b0;
        wr_ch = 3'd7; wr_opmask = 4'b1001;
        for (int i = 0; i < 140; i++) begin
            cen = 1'(i % 2);
            wr_valid = (i == 0);
            pre = slot_m; pc = cen;
            step(); chk_pipe();
            if (pc && pre == 5'd31 && !done) begin
                done = 1'b1;
                exp_mask[7] = 4'b1001;
                chk("cen_commit_slot", 32'(slot_II), 32'd31);
                chk("cen_commit_level", 32'(fifo_level), 32'd0);
            end
        end
        wr_valid = 1'b0;
        rd_ch = 3'd7; #1;
        chk("cen_rd_ch7", 32'(rd_mask), 32'h9);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/jt51_kon_sched.md
Name: jt51_kon_sched

Overview:
- Key-on scheduler for the 32-slot operator pipeline.
- Owns the free-running slot counter and the frame `zero` marker.
- Buffers CPU key-on writes (channel + 4-bit operator mask) in a small FIFO.
- Commits each write at a channel-safe slot boundary, so all four operators of a channel change key state in the same frame.
- Drives the serial per-slot `keyon_II` stream consumed by the envelope generator, which detects edges against the value 32 slots earlier.

Parameters:
- FIFO_DEPTH, 4, number of pending key-on writes; power of two, range 2..16.
- LW, 3, width of fifo_level minus 1; must satisfy 2^LW >= FIFO_DEPTH.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- cen  in  1  clock enable; slot pipeline advances only when 1
- wr_valid  in  1  CPU key-on write request
- wr_ready  out  1  FIFO can accept a write
- wr_ch  in  3  target channel 0..7
- wr_opmask  in  4  key state per operator group; bit i applies to slot {i[1:0],ch}
- rd_ch  in  3  readback channel select
- rd_mask  out  4  committed key state of rd_ch (combinational from state)
- fifo_level  out  LW+1  pending entries
- busy  out  1  fifo_level != 0
- slot_II  out  5  slot index for the keyon_II sample
- keyon_II  out  1  committed key-on bit for slot_II
- zero  out  1  1 while slot_II == 0

Behaviour:
- Reset (rst_n=0 at posedge): slot_cnt=0, kon_state[31:0]=0, FIFO emptied (pending writes discarded), slot_II=0, keyon_II=0, zero=0, fifo_level=0, busy=0, wr_ready=1.
- Reset mid-operation clears everything; no commit occurs in the reset cycle.
- Slot layout: slot = {op[1:0], ch[2:0]}. Operator group `op` of channel `ch` is visited at slot 8*op+ch.
- Slot pipeline, on posedge with cen=1:
  - slot_II <= slot_cnt
  - keyon_II <= kon_state[slot_cnt] (old value)
  - zero <= (slot_cnt==0)
  - slot_cnt <= slot_cnt+1, wrapping 31->0
- Slot pipeline with cen=0: slot_cnt, slot_II, keyon_II, zero and kon_state all hold.
- Output latency is 1 cen-cycle. slot_II, keyon_II and zero are always mutually aligned.
- Write side is independent of cen:
  - Push when wr_valid && wr_ready at posedge.
  - wr_ready = !full, registered from the level; it does not rise in the cycle of a simultaneous pop while full.
  - Write data must be held stable while wr_valid=1 && wr_ready=0.
- Commit rule: on posedge with cen=1, FIFO non-empty, and slot_cnt == {2'b11, head.ch}:
  - kon_state[{i,head.ch}] <= head.mask[i] for i=0..3
  - pop the head
- The read of kon_state[slot_cnt] in the commit cycle returns the old value, so all four operators show the new state from the next frame. No mixed-state frame is possible.
- At most one commit per cen-cycle. Entries commit strictly in FIFO order.
- A head entry waits up to 31 cen-cycles for its slot. Entries for the same channel commit in consecutive frames; each mask is visible for at least one full frame, so EG edge detection is never missed.
- Push and pop in the same posedge: fifo_level unchanged. Push into a full FIFO cannot occur (wr_ready=0). Pop from empty cannot occur.
- rd_mask = {kon_state[24+rd_ch], kon_state[16+rd_ch], kon_state[8+rd_ch], kon_state[rd_ch]}; it reflects commits on the following clock.
- No error outputs; overflow is prevented by the handshake.

Test Plan:
- Reset: hold rst_n=0 for 3 clk with cen=1 -> keyon_II=0, slot_II=0, zero=0, wr_ready=1, fifo_level=0, busy=0. Release -> zero=1 on first cen where slot_II=0, then again every 32 cen.
- Single commit: push ch=2, mask=4'hF while slot_cnt=5 -> commit at slot_cnt=26. keyon_II=0 for slot_II=26 in that frame, and 1 for slot_II 2,10,18,26 in every following frame. rd_ch=2 gives rd_mask=4'hF.
- Same-channel sequence: push ch=5 mask=4'b0101, then ch=5 mask=4'b0000 -> keyon_II=1 on slot_II 5 and 21 for exactly one frame, then 0. Commits are 32 cen apart.
- Back-pressure: cen=0, push 4 entries -> wr_ready=0 and fifo_level=4. A 5th request held with wr_valid=1 is accepted on the clock after the first pop once cen resumes. All 5 commit in order.
- Reset mid-operation: kon_state ch0=4'hF with 2 entries pending; assert rst_n=0 for 1 clk -> all keyon_II=0, fifo_level=0, and no pending entry ever commits.
- cen gating: cen high every other clk -> slot_II advances only on cen cycles, zero stays high for 2 clk per frame, and the commit still lands at slot {3,ch}.
